// File: rtl/sb_mem_arbiter_pkg.sv
// Shared types and constants for the I-cache / stream-buffer AXI read arbiter.
package sb_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    localparam logic ARB_ID_IC = 1'b0;
    localparam logic ARB_ID_SB = 1'b1;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

endpackage

// File: rtl/sb_mem_arbiter_if.sv
// AXI read address/data channel between the arbiter (master) and memory (slave).
interface sb_mem_arbiter_if
    import sb_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
);
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arlen;
    logic              arid;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic              rid;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output araddr, arlen, arid, arvalid, rready,
        input  arready, rdata, rid, rlast, rvalid
    );

    modport slave (
        input  araddr, arlen, arid, arvalid, rready,
        output arready, rdata, rid, rlast, rvalid
    );
endinterface

// File: rtl/sb_mem_arbiter_starve_counter.sv
// Saturating count of consecutive I-cache grants taken while a prefetch waits.
module arb_starve_counter
    import sb_mem_arbiter_pkg::*;
#(
    parameter int LIMIT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic full_o
);
    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] MAX = CW'(LIMIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins over increment; hold at MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CW{1'b0}};
        end else if (inc_i && (cnt_q != MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign full_o = (cnt_q == MAX);
endmodule

// File: rtl/sb_mem_arbiter.sv
// Arbitrates one AXI read channel between I-cache refills (id 0) and stream-buffer prefetches (id 1).
module sb_mem_arbiter
    import sb_mem_arbiter_pkg::*;
#(
    parameter int LINE_WORDS   = 4,
    parameter int STARVE_LIMIT = 3,
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int DATA_W       = ARB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req_valid_i,
    input  logic [ADDR_W-1:0] ic_req_addr_i,
    output logic              ic_req_ready_o,
    input  logic              sb_req_valid_i,
    input  logic [ADDR_W-1:0] sb_req_addr_i,
    output logic              sb_req_ready_o,
    input  logic              sb_flush_i,
    output logic              ic_rvalid_o,
    output logic [DATA_W-1:0] ic_rdata_o,
    output logic              ic_rlast_o,
    output logic              sb_rvalid_o,
    output logic [DATA_W-1:0] sb_rdata_o,
    output logic              sb_rlast_o,
    output logic              busy_o,
    output logic              proto_err_o,
    sb_mem_arbiter_if.master  axi
);
    localparam int BW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              id_q, id_d;
    logic              discard_q, discard_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic              perr_q, perr_d;

    logic grant_ic_s;
    logic grant_sb_s;
    logic starve_full_s;
    logic flush_s;
    logic last_beat_s;
    logic beat_fire_s;

    assign flush_s     = sb_flush_i && (id_q == ARB_ID_SB);
    assign last_beat_s = (beat_q == LAST_BEAT);

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (grant_ic_s && sb_req_valid_i),
        .clr_i  (grant_sb_s || !sb_req_valid_i),
        .full_o (starve_full_s)
    );

    // Next-state, grant selection, discard marking and protocol checks.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        id_d       = id_q;
        discard_d  = discard_q;
        beat_d     = beat_q;
        perr_d     = perr_q;
        grant_ic_s = 1'b0;
        grant_sb_s = 1'b0;

        if (axi.rvalid && (state_q != ARB_DATA)) begin
            perr_d = 1'b1;
        end else begin
            perr_d = perr_q;
        end

        case (state_q)
            ARB_IDLE: begin
                if (sb_req_valid_i && starve_full_s) begin
                    grant_sb_s = 1'b1;
                end else if (ic_req_valid_i) begin
                    grant_ic_s = 1'b1;
                end else if (sb_req_valid_i) begin
                    grant_sb_s = 1'b1;
                end else begin
                    grant_ic_s = 1'b0;
                end
                if (grant_ic_s || grant_sb_s) begin
                    state_d   = ARB_ADDR;
                    addr_d    = grant_sb_s ? sb_req_addr_i : ic_req_addr_i;
                    id_d      = grant_sb_s ? ARB_ID_SB : ARB_ID_IC;
                    discard_d = 1'b0;
                    beat_d    = {BW{1'b0}};
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_ADDR: begin
                // arvalid must stay up once raised, so a flush only marks the burst.
                if (flush_s) begin
                    discard_d = 1'b1;
                end else begin
                    discard_d = discard_q;
                end
                if (axi.arready) begin
                    state_d = ARB_DATA;
                end else begin
                    state_d = ARB_ADDR;
                end
            end
            ARB_DATA: begin
                if (flush_s) begin
                    discard_d = 1'b1;
                end else begin
                    discard_d = discard_q;
                end
                if (axi.rvalid) begin
                    beat_d = beat_q + BW'(1);
                    if ((axi.rid != id_q) || (axi.rlast != last_beat_s)) begin
                        perr_d = 1'b1;
                    end else begin
                        perr_d = perr_d;
                    end
                    if (axi.rlast || last_beat_s) begin
                        state_d = ARB_IDLE;
                        beat_d  = {BW{1'b0}};
                    end else begin
                        state_d = ARB_DATA;
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and burst-context registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            addr_q    <= {ADDR_W{1'b0}};
            id_q      <= ARB_ID_IC;
            discard_q <= 1'b0;
            beat_q    <= {BW{1'b0}};
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            id_q      <= id_d;
            discard_q <= discard_d;
            beat_q    <= beat_d;
            perr_q    <= perr_d;
        end
    end

    assign axi.arvalid = (state_q == ARB_ADDR);
    assign axi.araddr  = addr_q;
    assign axi.arid    = id_q;
    assign axi.arlen   = 4'(LINE_WORDS - 1);
    assign axi.rready  = (state_q == ARB_DATA);

    assign ic_req_ready_o = (state_q == ARB_ADDR) && axi.arready && (id_q == ARB_ID_IC) && !rst;
    assign sb_req_ready_o = (state_q == ARB_ADDR) && axi.arready && (id_q == ARB_ID_SB) && !rst;

    // Beats pass through combinationally; a same-cycle flush already hides the beat.
    assign beat_fire_s = (state_q == ARB_DATA) && axi.rvalid;
    assign ic_rvalid_o = beat_fire_s && (id_q == ARB_ID_IC);
    assign sb_rvalid_o = beat_fire_s && (id_q == ARB_ID_SB) && !discard_q && !sb_flush_i;
    assign ic_rdata_o  = ic_rvalid_o ? axi.rdata : {DATA_W{1'b0}};
    assign ic_rlast_o  = ic_rvalid_o && axi.rlast;
    assign sb_rdata_o  = sb_rvalid_o ? axi.rdata : {DATA_W{1'b0}};
    assign sb_rlast_o  = sb_rvalid_o && axi.rlast;

    assign busy_o      = (state_q != ARB_IDLE);
    assign proto_err_o = perr_q;
endmodule

// File: tb/tb_sb_mem_arbiter.sv
// Directed bench for sb_mem_arbiter: acts as memory and requesters, scoreboards routed beats.
module tb_sb_mem_arbiter;
    import sb_mem_arbiter_pkg::*;

    localparam int LW = 4;

    typedef struct packed {
        logic        dest;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_req_valid, sb_req_valid, sb_flush;
    logic [31:0] ic_req_addr, sb_req_addr;
    logic        ic_req_ready, sb_req_ready;
    logic        ic_rvalid, ic_rlast, sb_rvalid, sb_rlast;
    logic [31:0] ic_rdata, sb_rdata;
    logic        busy, proto_err;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];

    sb_mem_arbiter_if axi ();

    sb_mem_arbiter #(
        .LINE_WORDS   (LW),
        .STARVE_LIMIT (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ic_req_valid_i (ic_req_valid),
        .ic_req_addr_i  (ic_req_addr),
        .ic_req_ready_o (ic_req_ready),
        .sb_req_valid_i (sb_req_valid),
        .sb_req_addr_i  (sb_req_addr),
        .sb_req_ready_o (sb_req_ready),
        .sb_flush_i     (sb_flush),
        .ic_rvalid_o    (ic_rvalid),
        .ic_rdata_o     (ic_rdata),
        .ic_rlast_o     (ic_rlast),
        .sb_rvalid_o    (sb_rvalid),
        .sb_rdata_o     (sb_rdata),
        .sb_rlast_o     (sb_rlast),
        .busy_o         (busy),
        .proto_err_o    (proto_err),
        .axi            (axi)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat_data(input logic [31:0] a, input int b);
        logic [7:0] bb;
        bb = b[7:0];
        return {8'hD0, a[15:0], bb};
    endfunction

    // Waits (bounded) for arvalid; returns the number of negedges waited.
    task automatic wait_arvalid(output int lat);
        lat = 0;
        #1;
        while (axi.arvalid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check("arvalid_seen", axi.arvalid, 1'b1);
    endtask

    // Called at a negedge: drives one R beat, scoreboards it and checks routing.
    task automatic drive_beat(input logic id, input logic [31:0] d, input logic last,
                              input logic flush, input logic discard);
        beat_t e;
        logic  vis;
        logic  [31:0] got_d;
        logic  got_l;
        axi.rvalid = 1'b1;
        axi.rdata  = d;
        axi.rlast  = last;
        axi.rid    = id;
        sb_flush   = flush;
        vis = (id == ARB_ID_IC) || !(discard || flush);
        if (vis) begin
            e.dest = id;
            e.data = d;
            e.last = last;
            exp_q.push_back(e);
        end
        #1;
        check("rready", axi.rready, 1'b1);
        check("ic_rvalid", ic_rvalid, vis && (id == ARB_ID_IC));
        check("sb_rvalid", sb_rvalid, vis && (id == ARB_ID_SB));
        if (ic_rvalid === 1'b1 || sb_rvalid === 1'b1) begin
            check("scoreboard_nonempty", (exp_q.size() > 0), 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got_d = (ic_rvalid === 1'b1) ? ic_rdata : sb_rdata;
                got_l = (ic_rvalid === 1'b1) ? ic_rlast : sb_rlast;
                check("beat_dest", sb_rvalid, e.dest);
                check("beat_data", got_d, e.data);
                check("beat_last", got_l, e.last);
            end
        end
    endtask

    // Serves one whole burst from the memory side once arvalid shows up.
    task automatic run_burst(input logic id, input logic [31:0] addr, input int stall,
                             input bit flush_addr, input int flush_beat, input int last_at,
                             input bit keep_ic, input logic [31:0] next_ic, input int exp_lat);
        int   lat;
        int   nb;
        logic disc;
        logic fl;
        wait_arvalid(lat);
        if (exp_lat >= 0) check("ar_latency", lat, exp_lat);
        check("arid", axi.arid, id);
        check("araddr", axi.araddr, addr);
        check("arlen", axi.arlen, LW - 1);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            axi.arready = 1'b0;
            sb_flush = flush_addr && (i % 2 == 0);
            #1;
            check("stall_arvalid", axi.arvalid, 1'b1);
            check("stall_araddr", axi.araddr, addr);
            check("stall_ready", {ic_req_ready, sb_req_ready}, 2'b00);
        end
        @(negedge clk);
        sb_flush    = 1'b0;
        axi.arready = 1'b1;
        #1;
        check("ic_req_ready", ic_req_ready, id == ARB_ID_IC);
        check("sb_req_ready", sb_req_ready, id == ARB_ID_SB);
        disc = flush_addr;
        nb = (last_at >= 0) ? last_at + 1 : LW;
        for (int b = 0; b < nb; b++) begin
            @(negedge clk);
            if (b == 0) begin
                axi.arready = 1'b0;
                if (id == ARB_ID_SB) sb_req_valid = 1'b0;
                else if (keep_ic) ic_req_addr = next_ic;
                else ic_req_valid = 1'b0;
            end
            fl = (b == flush_beat);
            drive_beat(id, beat_data(addr, b), (b == nb - 1), fl, disc);
            if (fl && id == ARB_ID_SB) disc = 1'b1;
        end
        @(negedge clk);
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        sb_flush   = 1'b0;
        #1;
        check("idle_after_burst", busy, 1'b0);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        ic_req_valid = 1'b0; ic_req_addr = 32'h0;
        sb_req_valid = 1'b0; sb_req_addr = 32'h0;
        sb_flush = 1'b0;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = 32'h0;
        axi.rid = 1'b0; axi.rlast = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_arvalid", axi.arvalid, 1'b0);
        check("rst_araddr", axi.araddr, 32'h0);
        check("rst_arlen", axi.arlen, 4'd3);
        check("rst_rready", axi.rready, 1'b0);
        check("rst_proto_err", proto_err, 1'b0);

        // T1: single I-cache refill
        @(negedge clk);
        rst = 1'b0;
        ic_req_valid = 1'b1; ic_req_addr = 32'h100;
        run_burst(ARB_ID_IC, 32'h100, 0, 1'b0, -1, -1, 1'b0, 32'h0, 1);

        // T2: simultaneous requests, I-cache first
        @(negedge clk);
        ic_req_valid = 1'b1; ic_req_addr = 32'h200;
        sb_req_valid = 1'b1; sb_req_addr = 32'h300;
        run_burst(ARB_ID_IC, 32'h200, 0, 1'b0, -1, -1, 1'b0, 32'h0, 1);
        run_burst(ARB_ID_SB, 32'h300, 0, 1'b0, -1, -1, 1'b0, 32'h0, -1);

        // T3: starvation forces an SB grant after three I-cache grants
        @(negedge clk);
        sb_req_valid = 1'b1; sb_req_addr = 32'h400;
        ic_req_valid = 1'b1; ic_req_addr = 32'h500;
        run_burst(ARB_ID_IC, 32'h500, 0, 1'b0, -1, -1, 1'b1, 32'h540, -1);
        run_burst(ARB_ID_IC, 32'h540, 0, 1'b0, -1, -1, 1'b1, 32'h580, -1);
        run_burst(ARB_ID_IC, 32'h580, 0, 1'b0, -1, -1, 1'b1, 32'h5C0, -1);
        run_burst(ARB_ID_SB, 32'h400, 0, 1'b0, -1, -1, 1'b0, 32'h0, -1);
        run_burst(ARB_ID_IC, 32'h5C0, 0, 1'b0, -1, -1, 1'b0, 32'h0, -1);

        // T4: flush on beat 1, then normal traffic
        @(negedge clk);
        sb_req_valid = 1'b1; sb_req_addr = 32'h600;
        run_burst(ARB_ID_SB, 32'h600, 0, 1'b0, 1, -1, 1'b0, 32'h0, -1);
        @(negedge clk);
        ic_req_valid = 1'b1; ic_req_addr = 32'h700;
        run_burst(ARB_ID_IC, 32'h700, 0, 1'b0, -1, -1, 1'b0, 32'h0, -1);
        @(negedge clk);
        sb_req_valid = 1'b1; sb_req_addr = 32'h640;
        run_burst(ARB_ID_SB, 32'h640, 0, 1'b0, -1, -1, 1'b0, 32'h0, -1);

        // T5: arready stall with flush during ADDR discards every beat
        @(negedge clk);
        sb_req_valid = 1'b1; sb_req_addr = 32'h800;
        run_burst(ARB_ID_SB, 32'h800, 5, 1'b1, -1, -1, 1'b0, 32'h0, -1);
        check("no_err_before_t6", proto_err, 1'b0);

        // T6: early rlast sets proto_err, then reset mid-DATA clears everything
        @(negedge clk);
        ic_req_valid = 1'b1; ic_req_addr = 32'h900;
        run_burst(ARB_ID_IC, 32'h900, 0, 1'b0, -1, 2, 1'b0, 32'h0, -1);
        check("proto_err_set", proto_err, 1'b1);

        @(negedge clk);
        ic_req_valid = 1'b1; ic_req_addr = 32'hA00;
        wait_arvalid(lat);
        @(negedge clk);
        axi.arready = 1'b1;
        @(negedge clk);
        axi.arready = 1'b0;
        ic_req_valid = 1'b0;
        drive_beat(ARB_ID_IC, beat_data(32'hA00, 0), 1'b0, 1'b0, 1'b0);
        check("t6_busy_in_data", busy, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        axi.rvalid = 1'b0;
        @(negedge clk);
        #1;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_arvalid", axi.arvalid, 1'b0);
        check("rst_mid_rready", axi.rready, 1'b0);
        check("rst_mid_araddr", axi.araddr, 32'h0);
        check("rst_mid_rvalid", {ic_rvalid, sb_rvalid}, 2'b00);
        check("rst_mid_proto_err", proto_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
